// File: rtl/axo32_operand_stage.sv
// Operand stage ahead of the RV32IM ALU: two-entry skid buffer (A = output, B = skid)
// with writeback forwarding at capture and snooping of held entries.
module axo32_operand_stage #(
    parameter logic [31:0] RESET_PC_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_insn,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_insn,
    output logic [31:0] out_pc,
    output logic [31:0] out_lhs,
    output logic [31:0] out_rhs,
    output logic [31:0] out_store_data
);

    logic        r_a_valid, r_b_valid;
    logic [31:0] r_a_insn, r_a_pc, r_a_rs1v, r_a_rs2v;
    logic [31:0] r_b_insn, r_b_pc, r_b_rs1v, r_b_rs2v;

    logic        w_acc, w_wb_hit;
    logic [31:0] w_in_rs1, w_in_rs2, w_a_rs1, w_a_rs2, w_b_rs1, w_b_rs2;

    // x0 is hardwired zero, so a writeback to it must never be forwarded
    assign w_wb_hit = wb_en && (wb_rd != 5'd0);
    assign w_acc    = in_valid && !r_b_valid && !flush;

    assign w_in_rs1 = (w_wb_hit && wb_rd == in_insn[19:15]) ? wb_data : in_rs1_val;
    assign w_in_rs2 = (w_wb_hit && wb_rd == in_insn[24:20]) ? wb_data : in_rs2_val;
    assign w_a_rs1  = (r_a_valid && w_wb_hit && wb_rd == r_a_insn[19:15]) ? wb_data : r_a_rs1v;
    assign w_a_rs2  = (r_a_valid && w_wb_hit && wb_rd == r_a_insn[24:20]) ? wb_data : r_a_rs2v;
    assign w_b_rs1  = (r_b_valid && w_wb_hit && wb_rd == r_b_insn[19:15]) ? wb_data : r_b_rs1v;
    assign w_b_rs2  = (r_b_valid && w_wb_hit && wb_rd == r_b_insn[24:20]) ? wb_data : r_b_rs2v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_valid <= 1'b0;
            r_a_insn  <= 32'h0000_0013;
            r_a_pc    <= RESET_PC_VAL;
            r_a_rs1v  <= 32'h0;
            r_a_rs2v  <= 32'h0;
            r_b_valid <= 1'b0;
            r_b_insn  <= 32'h0000_0013;
            r_b_pc    <= 32'h0;
            r_b_rs1v  <= 32'h0;
            r_b_rs2v  <= 32'h0;
        end else if (flush) begin
            r_a_valid <= 1'b0;
            r_b_valid <= 1'b0;
        end else begin
            if (r_a_valid && out_ready && r_b_valid) begin
                // B moves to A carrying this edge's snoop
                r_a_insn  <= r_b_insn;
                r_a_pc    <= r_b_pc;
                r_a_rs1v  <= w_b_rs1;
                r_a_rs2v  <= w_b_rs2;
                r_b_valid <= 1'b0;
            end else if ((!r_a_valid || out_ready) && w_acc) begin
                r_a_valid <= 1'b1;
                r_a_insn  <= in_insn;
                r_a_pc    <= in_pc;
                r_a_rs1v  <= w_in_rs1;
                r_a_rs2v  <= w_in_rs2;
            end else if (r_a_valid && out_ready) begin
                r_a_valid <= 1'b0;
            end else begin
                r_a_rs1v  <= w_a_rs1;
                r_a_rs2v  <= w_a_rs2;
            end

            if (r_a_valid && !out_ready && w_acc) begin
                r_b_valid <= 1'b1;
                r_b_insn  <= in_insn;
                r_b_pc    <= in_pc;
                r_b_rs1v  <= w_in_rs1;
                r_b_rs2v  <= w_in_rs2;
            end else begin
                r_b_rs1v  <= w_b_rs1;
                r_b_rs2v  <= w_b_rs2;
            end
        end
    end

    logic [31:0] w_imm_i, w_imm_s, w_imm_u;
    assign w_imm_i = {{20{r_a_insn[31]}}, r_a_insn[31:20]};
    assign w_imm_s = {{20{r_a_insn[31]}}, r_a_insn[31:25], r_a_insn[11:7]};
    assign w_imm_u = {r_a_insn[31:12], 12'b0};

    always_comb begin
        out_lhs = r_a_rs1v;
        out_rhs = r_a_rs2v;
        case (r_a_insn[6:0])
            7'b0110111: begin out_lhs = 32'h0;    out_rhs = w_imm_u; end
            7'b0010111: begin out_lhs = r_a_pc;   out_rhs = w_imm_u; end
            7'b1101111,
            7'b1100111: begin out_lhs = r_a_pc;   out_rhs = 32'd4;   end
            7'b0000011,
            7'b0010011: begin out_lhs = r_a_rs1v; out_rhs = w_imm_i; end
            7'b0100011: begin out_lhs = r_a_rs1v; out_rhs = w_imm_s; end
            default:    begin out_lhs = r_a_rs1v; out_rhs = r_a_rs2v; end
        endcase
    end

    assign in_ready       = !r_b_valid;
    assign out_valid      = r_a_valid;
    assign out_insn       = r_a_insn;
    assign out_pc         = r_a_valid ? r_a_pc : RESET_PC_VAL;
    assign out_store_data = r_a_rs2v;

endmodule

// File: tb/tb_axo32_operand_stage.sv
// Directed bench for axo32_operand_stage; inputs driven and outputs sampled at the falling edge.
module tb_axo32_operand_stage;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic [31:0] in_insn, in_pc, in_rs1_val, in_rs2_val;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [31:0] out_insn, out_pc, out_lhs, out_rhs, out_store_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axo32_operand_stage #(.RESET_PC_VAL(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_insn(in_insn), .in_pc(in_pc),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_insn(out_insn), .out_pc(out_pc),
        .out_lhs(out_lhs), .out_rhs(out_rhs), .out_store_data(out_store_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [31:0] insn, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2);
        in_valid   = 1'b1;
        in_insn    = insn;
        in_pc      = pc;
        in_rs1_val = rs1;
        in_rs2_val = rs2;
    endtask

    task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] d);
        wb_en = en; wb_rd = rd; wb_data = d;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_insn = 32'h0; in_pc = 32'h0; in_rs1_val = 32'h0; in_rs2_val = 32'h0;
        wb(1'b0, 5'd0, 32'h0);
        step(); step();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready}, 32'd1);
        chk("rst_insn",  out_insn, 32'h0000_0013);
        chk("rst_pc",    out_pc, RST_PC);
        chk("rst_lhs",   out_lhs, 32'h0);
        chk("rst_rhs",   out_rhs, 32'h0);
        chk("rst_sd",    out_store_data, 32'h0);
        rst_n = 1'b1;

        // ADDI x1,x2,-5
        beat(32'hFFB1_0093, 32'h0, 32'd10, 32'd0);
        step();
        chk("addi_valid", {31'b0, out_valid}, 32'd1);
        chk("addi_lhs", out_lhs, 32'd10);
        chk("addi_rhs", out_rhs, 32'hFFFF_FFFB);

        // AUIPC x3,0x12345
        beat(32'h1234_5197, 32'h100, 32'h0, 32'h0);
        step();
        chk("auipc_lhs", out_lhs, 32'h100);
        chk("auipc_rhs", out_rhs, 32'h1234_5000);

        // JAL x0,0
        beat(32'h0000_006F, 32'h200, 32'h5, 32'h6);
        step();
        chk("jal_lhs", out_lhs, 32'h200);
        chk("jal_rhs", out_rhs, 32'd4);

        // SW x5,-4(x6) with same-cycle writeback to x5
        beat(32'hFE53_2E23, 32'h204, 32'h1000, 32'd7);
        wb(1'b1, 5'd5, 32'd9);
        step();
        chk("sw_lhs", out_lhs, 32'h1000);
        chk("sw_rhs", out_rhs, 32'hFFFF_FFFC);
        chk("sw_fwd_sd", out_store_data, 32'd9);

        // SW x0,-4(x6) with writeback to x0: not forwarded
        beat(32'hFE03_2E23, 32'h208, 32'h1000, 32'd7);
        wb(1'b1, 5'd0, 32'd9);
        step();
        chk("sw_x0_sd", out_store_data, 32'd7);
        chk("sw_x0_lhs", out_lhs, 32'h1000);
        wb(1'b0, 5'd0, 32'h0);
        in_valid = 1'b0;
        step();
        chk("drain_valid", {31'b0, out_valid}, 32'd0);
        chk("empty_pc", out_pc, RST_PC);

        // Stall: three back-to-back ADDIs with out_ready low
        out_ready = 1'b0;
        beat(32'h0011_0093, 32'h10, 32'h11, 32'h0);   // addi x1,x2,1
        step();
        chk("st1_valid", {31'b0, out_valid}, 32'd1);
        chk("st1_lhs", out_lhs, 32'h11);
        chk("st1_in_ready", {31'b0, in_ready}, 32'd1);
        beat(32'h0021_8093, 32'h14, 32'h22, 32'h0);   // addi x1,x3,2
        step();
        chk("st2_in_ready", {31'b0, in_ready}, 32'd0);
        chk("st2_pc_held", out_pc, 32'h10);
        beat(32'h0032_0093, 32'h18, 32'h33, 32'h0);   // addi x1,x4,3
        wb(1'b1, 5'd3, 32'h99);                        // updates B's rs1
        step();
        chk("st3_in_ready", {31'b0, in_ready}, 32'd0);
        chk("st3_pc_held", out_pc, 32'h10);
        chk("st3_lhs_held", out_lhs, 32'h11);
        out_ready = 1'b1;
        wb(1'b1, 5'd2, 32'h55);                        // snoop at the B->A move edge (rs2 index of beat 2)
        step();
        chk("rel2_pc", out_pc, 32'h14);
        chk("rel2_lhs", out_lhs, 32'h99);
        chk("rel2_rhs", out_rhs, 32'd2);
        chk("rel2_sd", out_store_data, 32'h55);
        chk("rel2_in_ready", {31'b0, in_ready}, 32'd1);
        wb(1'b0, 5'd0, 32'h0);
        step();
        chk("rel3_pc", out_pc, 32'h18);
        chk("rel3_lhs", out_lhs, 32'h33);
        in_valid = 1'b0;
        step();
        chk("rel_end_valid", {31'b0, out_valid}, 32'd0);

        // Flush with A and B full and a beat on the input
        out_ready = 1'b0;
        beat(32'h0011_0093, 32'h20, 32'h1, 32'h0);
        step();
        beat(32'h0021_8093, 32'h24, 32'h2, 32'h0);
        step();
        chk("fl_full", {31'b0, in_ready}, 32'd0);
        beat(32'h0032_0093, 32'h28, 32'h3, 32'h0);
        flush = 1'b1;
        step();
        chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_in_ready", {31'b0, in_ready}, 32'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("fl_after", {31'b0, out_valid}, 32'd0);

        // Flush kills an acceptable input beat
        beat(32'h0011_0093, 32'h30, 32'h1, 32'h0);
        step();
        beat(32'h0021_8093, 32'h34, 32'h2, 32'h0);
        flush = 1'b1;
        step();
        chk("fl2_out_valid", {31'b0, out_valid}, 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        step();
        chk("fl2_not_emitted", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset mid-stall
        out_ready = 1'b0;
        beat(32'h0011_0093, 32'h40, 32'h1, 32'h0);
        step();
        beat(32'h0021_8093, 32'h44, 32'h2, 32'h0);
        step();
        in_valid = 1'b0;
        chk("ar_pre_valid", {31'b0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", {31'b0, out_valid}, 32'd0);
        chk("ar_insn", out_insn, 32'h0000_0013);
        chk("ar_in_ready", {31'b0, in_ready}, 32'd1);
        chk("ar_pc", out_pc, RST_PC);
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        step();
        chk("ar_post_valid", {31'b0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
